matrix_result_streamer: RTL
===========================

Name: matrix_result_streamer

Overview:
- Downstream consumer of the 5x5 matrix multiplier.
- On a start pulse it snapshots the result matrix (row count, column count and 25 row-major elements at stride 5).
- It then emits a header (rows, cols) and the r x c valid elements one per beat over a valid/ready stream.
- The stream feeds the UART/display formatter.

Parameters:
- DATA_WIDTH, 9, width of each matrix element and of out_data.
- MAX_DIM, 5, maximum rows/cols; storage stride is fixed at 5.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  synchronous cancel, returns to IDLE.
- r_in  input  3  result row count.
- c_in  input  3  result column count.
- data_in_0 .. data_in_24  input  DATA_WIDTH each  result elements, index = 5*row + col.
- out_ready  input  1  downstream accepts the current beat.
- out_valid  output  1  beat present.
- out_data  output  DATA_WIDTH  header value (zero-extended) or element.
- out_is_header  output  1  beat is r or c header.
- out_row  output  3  row of the element beat (0 on headers).
- out_col  output  3  column of the element beat (0 on headers).
- out_eol  output  1  last element of a row.
- out_last  output  1  final element of the matrix.
- busy  output  1  high from the accepted start until the DONE state.
- done  output  1  one-cycle pulse after the final transfer.
- err  output  1  one-cycle pulse on start with illegal dimensions.

Behaviour:
- Reset (async, reset_n low): state IDLE; every output 0; snapshot registers 0.
- States: IDLE, HDR_R, HDR_C, DATA, DONE.
- Transfer: a beat transfers on a rising edge with out_valid && out_ready. While out_valid=1 and out_ready=0, all out_* are held stable.
- IDLE + start, r_in and c_in both in 1..5:
  - Latch r_in, c_in and all 25 elements.
  - Set row=0, col=0, busy=1, go to HDR_R.
  - Latency: out_valid rises the cycle after start.
- IDLE + start with r_in or c_in equal to 0 or >5: err=1 for one cycle, stay in IDLE, no beats.
- HDR_R: out_data=r, out_is_header=1. On transfer go to HDR_C.
- HDR_C: out_data=c, out_is_header=1. On transfer go to DATA.
- DATA:
  - out_data = snapshot[5*row+col], out_row=row, out_col=col.
  - out_eol = (col==c-1); out_last = (row==r-1 && col==c-1).
  - On transfer: if last, go to DONE. Else if eol, row++ and col=0. Else col++.
  - Columns >= c and rows >= r are never emitted.
- DONE: out_valid=0, done=1 for exactly one cycle, busy=0, then IDLE. The snapshot is retained until the next accepted start.
- start outside IDLE is ignored; it is not queued.
- abort in any non-IDLE state, on the next edge:
  - Go to IDLE; out_valid, busy and flags go to 0.
  - No done pulse.
  - abort takes priority over a simultaneous transfer.
- abort in IDLE: no effect.
- Input changes after the accepted start do not affect the stream, because of the snapshot.
- Throughput: with out_ready held 1, a matrix takes 2 + r*c beats on consecutive cycles, then one DONE cycle.
- No arithmetic is performed. Header values are zero-extended from 3 bits to DATA_WIDTH.

Decomposition:
- Shared package (matrix_pkg): MAX_DIM=5, ROW_STRIDE=5, NUM_ELEMS=25, and the stream state encoding (IDLE=0, HDR_R=1, HDR_C=2, DATA=3, DONE=4). The multiplier and the input loader reuse these.
- One natural sub-module: matrix_index_counter.
  - Inputs: r, c, clear, step.
  - Outputs: row, col, flat index, eol, last.
  - The input loader reuses it.
- Element selection is a 25:1 mux inside the top level.

Test Plan:
- 2x3 matrix, data_in_0..2=1,2,3 and data_in_5..7=4,5,6, out_ready=1, start at cycle 0:
  - Beats from cycle 1: 2,3 (header) then 1,2,3,4,5,6.
  - out_eol on elements 3 and 6; out_last on 6.
  - done pulse at cycle 9; busy low at cycle 9.
- Same matrix with out_ready toggling 1,0,0,1,...:
  - Beat order is unchanged.
  - out_data/out_row/out_col are stable during every stall.
  - Total beats = 8.
- start with r_in=0, c_in=3, then with r_in=6: err pulses once for each start, out_valid stays 0, busy stays 0.
- 5x5 stream; change data_in_24 and assert start again during the stream:
  - The second start is ignored.
  - The final beat is the original data_in_24 value, at row 4 / col 4, with out_last=1.
- abort asserted on the 3rd element beat of a 3x3 matrix: next cycle out_valid=0, busy=0, no done; a subsequent start streams the full matrix again.
- reset_n pulled low mid-DATA (asynchronous, between edges): all outputs are 0 immediately; after release, the block is in IDLE and a 1x1 start yields beats 1,1,d0 with out_last=1.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and stream state encoding for the 5x5 matrix datapath.
// Reused by the multiplier, the input loader and the result streamer.
package matrix_pkg;

  localparam int MAX_DIM    = 5;
  localparam int ROW_STRIDE = 5;
  localparam int NUM_ELEMS  = 25;
  localparam int DIM_W      = 3;
  localparam int IDX_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR_R = 3'd1,
    S_HDR_C = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } stream_state_t;

  function automatic logic [IDX_W-1:0] flat_idx(
    input logic [DIM_W-1:0] row,
    input logic [DIM_W-1:0] col
  );
    return IDX_W'(row) * IDX_W'(ROW_STRIDE) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Result beat stream: valid/ready handshake plus per-beat tags.
// The producer uses master, the formatter uses slave.
interface matrix_result_streamer_if #(
  parameter int DATA_WIDTH = 9
);
  import matrix_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_is_header;
  logic [DIM_W-1:0]      out_row;
  logic [DIM_W-1:0]      out_col;
  logic                  out_eol;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_is_header,
    output out_row,
    output out_col,
    output out_eol,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_is_header,
    input  out_row,
    input  out_col,
    input  out_eol,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/matrix_index_counter.sv
// Row-major walk over an r x c window of a stride-5 matrix.
// Holds at the last element until cleared.
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIM_W-1:0] r,
  input  logic [DIM_W-1:0] c,
  input  logic             clear,
  input  logic             step,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic [IDX_W-1:0] idx,
  output logic             eol,
  output logic             last
);

  // row/col position, wraps column at end of each row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step && !last) begin
      if (eol) begin
        row <= row + DIM_W'(1);
        col <= '0;
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  assign eol  = (col == c - DIM_W'(1));
  assign last = eol && (row == r - DIM_W'(1));
  assign idx  = flat_idx(row, col);

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots the multiplier result and streams it as
// header (rows, cols) followed by row-major elements.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_DIM    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_W-1:0]      r_in,
  input  logic [DIM_W-1:0]      c_in,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic [DATA_WIDTH-1:0] data_in_4,
  input  logic [DATA_WIDTH-1:0] data_in_5,
  input  logic [DATA_WIDTH-1:0] data_in_6,
  input  logic [DATA_WIDTH-1:0] data_in_7,
  input  logic [DATA_WIDTH-1:0] data_in_8,
  input  logic [DATA_WIDTH-1:0] data_in_9,
  input  logic [DATA_WIDTH-1:0] data_in_10,
  input  logic [DATA_WIDTH-1:0] data_in_11,
  input  logic [DATA_WIDTH-1:0] data_in_12,
  input  logic [DATA_WIDTH-1:0] data_in_13,
  input  logic [DATA_WIDTH-1:0] data_in_14,
  input  logic [DATA_WIDTH-1:0] data_in_15,
  input  logic [DATA_WIDTH-1:0] data_in_16,
  input  logic [DATA_WIDTH-1:0] data_in_17,
  input  logic [DATA_WIDTH-1:0] data_in_18,
  input  logic [DATA_WIDTH-1:0] data_in_19,
  input  logic [DATA_WIDTH-1:0] data_in_20,
  input  logic [DATA_WIDTH-1:0] data_in_21,
  input  logic [DATA_WIDTH-1:0] data_in_22,
  input  logic [DATA_WIDTH-1:0] data_in_23,
  input  logic [DATA_WIDTH-1:0] data_in_24,
  matrix_result_streamer_if.master strm,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  stream_state_t state, nxt;

  logic [DATA_WIDTH-1:0] din  [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] snap [NUM_ELEMS];
  logic [DIM_W-1:0]      snap_r;
  logic [DIM_W-1:0]      snap_c;
  logic [DATA_WIDTH-1:0] elem;
  logic                  err_q;

  logic                  dims_ok;
  logic                  accept;
  logic                  reject;
  logic                  xfer;
  logic                  cnt_step;

  logic [DIM_W-1:0]      cnt_row;
  logic [DIM_W-1:0]      cnt_col;
  logic [IDX_W-1:0]      cnt_idx;
  logic                  cnt_eol;
  logic                  cnt_last;

  assign din[0]  = data_in_0;
  assign din[1]  = data_in_1;
  assign din[2]  = data_in_2;
  assign din[3]  = data_in_3;
  assign din[4]  = data_in_4;
  assign din[5]  = data_in_5;
  assign din[6]  = data_in_6;
  assign din[7]  = data_in_7;
  assign din[8]  = data_in_8;
  assign din[9]  = data_in_9;
  assign din[10] = data_in_10;
  assign din[11] = data_in_11;
  assign din[12] = data_in_12;
  assign din[13] = data_in_13;
  assign din[14] = data_in_14;
  assign din[15] = data_in_15;
  assign din[16] = data_in_16;
  assign din[17] = data_in_17;
  assign din[18] = data_in_18;
  assign din[19] = data_in_19;
  assign din[20] = data_in_20;
  assign din[21] = data_in_21;
  assign din[22] = data_in_22;
  assign din[23] = data_in_23;
  assign din[24] = data_in_24;

  assign dims_ok = (r_in != '0) && (r_in <= DIM_MAX)
                && (c_in != '0) && (c_in <= DIM_MAX);
  assign accept  = (state == S_IDLE) && start && dims_ok;
  assign reject  = (state == S_IDLE) && start && !dims_ok;
  assign xfer    = strm.out_valid && strm.out_ready;
  assign cnt_step = (state == S_DATA) && xfer && !abort;

  matrix_index_counter u_idx (
    .clk     (clk),
    .reset_n (reset_n),
    .r       (snap_r),
    .c       (snap_c),
    .clear   (accept),
    .step    (cnt_step),
    .row     (cnt_row),
    .col     (cnt_col),
    .idx     (cnt_idx),
    .eol     (cnt_eol),
    .last    (cnt_last)
  );

  // 25:1 element select from the snapshot
  always_comb begin
    elem = '0;
    if (cnt_idx < IDX_W'(NUM_ELEMS)) begin
      elem = snap[cnt_idx];
    end
  end

  // capture dims and elements only on an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_r <= '0;
      snap_c <= '0;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        snap[i] <= '0;
      end
    end else if (accept) begin
      snap_r <= r_in;
      snap_c <= c_in;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        snap[i] <= din[i];
      end
    end
  end

  // state register and registered illegal-start pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= reject;
    end
  end

  // next state; abort beats any pending transfer
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (accept) nxt = S_HDR_R;
      S_HDR_R: if (xfer) nxt = S_HDR_C;
      S_HDR_C: if (xfer) nxt = S_DATA;
      S_DATA:  if (xfer && cnt_last) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      nxt = S_IDLE;
    end
  end

  // beat contents and status flags decoded from state
  always_comb begin
    strm.out_valid     = 1'b0;
    strm.out_data      = '0;
    strm.out_is_header = 1'b0;
    strm.out_row       = '0;
    strm.out_col       = '0;
    strm.out_eol       = 1'b0;
    strm.out_last      = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    err                = err_q;
    unique case (state)
      S_HDR_R: begin
        strm.out_valid     = 1'b1;
        strm.out_is_header = 1'b1;
        strm.out_data      = {{(DATA_WIDTH-DIM_W){1'b0}}, snap_r};
        busy               = 1'b1;
      end
      S_HDR_C: begin
        strm.out_valid     = 1'b1;
        strm.out_is_header = 1'b1;
        strm.out_data      = {{(DATA_WIDTH-DIM_W){1'b0}}, snap_c};
        busy               = 1'b1;
      end
      S_DATA: begin
        strm.out_valid = 1'b1;
        strm.out_data  = elem;
        strm.out_row   = cnt_row;
        strm.out_col   = cnt_col;
        strm.out_eol   = cnt_eol;
        strm.out_last  = cnt_last;
        busy           = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
